// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int DEF_OPW = 3;
    localparam int DEF_DW  = 5;
    localparam int DEF_RW  = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Command word at the default widths: 13 bits.
    typedef struct packed {
        logic [DEF_OPW-1:0] op;
        logic [DEF_DW-1:0]  a;
        logic [DEF_DW-1:0]  b;
    } cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Command FIFO: DEPTH entries, push/pop with full/empty/count.
// Latency: pushed data is visible at the head on the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full is registered.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            push_en, pop_en;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Next pointers and occupancy; power-of-two depth makes the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        count_d  = count_q + CNTW'(push_en) - CNTW'(pop_en);
    end

    // Pointer and count state; contents are discarded on reset by clearing these.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/alu_seq_driver.sv
// Buffers ALU commands, drives the registered ALU, returns each result (ALU_SEQ_STATS_EN adds counters).
// Latency: rsp_valid rises on the 4th edge counting the accepting one (push, pop, ALU reg, capture).
// Backpressure: cmd_ready low while FIFO full; response held stable until rsp_ready.
module alu_seq_driver
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OPW   = DEF_OPW,
    parameter int DW    = DEF_DW,
    parameter int RW    = DEF_RW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [DW-1:0]  cmd_a,
    input  logic [DW-1:0]  cmd_b,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_in1,
    output logic [DW-1:0]  alu_in2,
    input  logic [RW-1:0]  alu_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [RW-1:0]  rsp_data,
    output logic [OPW-1:0] rsp_op,
    output logic           busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]    stat_issued,
    output logic [15:0]    stat_stall
`endif
);
    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } cmd_w_t;

    localparam int CW = OPW + 2 * DW;

    cmd_w_t                 push_cmd, head_cmd;
    logic                   fifo_full, fifo_empty, fifo_push, pop;
    logic [$clog2(DEPTH):0] fifo_count;

    state_t         state_q, state_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic [DW-1:0]  alu_in1_q, alu_in1_d;
    logic [DW-1:0]  alu_in2_q, alu_in2_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]  rsp_data_q, rsp_data_d;
    logic [OPW-1:0] rsp_op_q, rsp_op_d;

    assign push_cmd  = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    alu_seq_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (push_cmd),
        .pop      (pop),
        .pop_dat  (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign alu_op    = alu_op_q;
    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign busy      = (state_q != S_IDLE) || (fifo_count != '0);

    // Sequencer: pop and drive the ALU, wait one cycle for its register, capture, hold until taken.
    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    alu_op_d  = head_cmd.op;
                    alu_in1_d = head_cmd.a;
                    alu_in2_d = head_cmd.b;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                rsp_data_d  = alu_result;
                rsp_op_d    = alu_op_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        alu_op_d  = head_cmd.op;
                        alu_in1_d = head_cmd.a;
                        alu_in2_d = head_cmd.b;
                        state_d   = S_ISSUE;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and registered outputs; reset drops any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            alu_op_q    <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;

    // Saturating counters: commands popped, and cycles a held response waits on the consumer.
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (pop && (stat_issued_q != 16'hFFFF)) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end
        if ((state_q == S_RESP) && !rsp_ready && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
